load_use_scoreboard_hdu: RTL and testbench

Parametrised load-use hazard detection unit for the pipelined MIPS core. It sits beside the ID stage. It keeps an internal shadow scoreboard of in-flight load destinations, so load-to-use latencies longer than one cycle are handled with no extra pipeline taps. It drives PC/IF_ID write enables and the ID/EX bubble, and honours data-memory busy freezes and branch flushes.

---
 rtl/load_use_scoreboard_hdu.sv | 113 +++++++++++
 tb/tb_load_use_scoreboard_hdu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/load_use_scoreboard_hdu.sv
// Load-use hazard detection unit with a shadow scoreboard of in-flight load destinations.
// Optional stall-cycle counter enabled by defining HDU_STALL_CNT_EN.
module load_use_scoreboard_hdu #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic              rs_used_i,
    input  logic              rt_used_i,
    input  logic              ID_MEMRead_i,
    input  logic [REG_AW-1:0] ID_Rt_i,
    input  logic              Flush_i,
    input  logic              Mem_Busy_i,
    output logic              PCWrite_o,
    output logic              IF_IDWrite_o,
    output logic              Stall_o
`ifdef HDU_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  Stall_Cnt_o
`endif
);

    if (LOAD_LAT < 1 || LOAD_LAT > 4 || CNT_W < 1) begin : g_param_err
        $error("load_use_scoreboard_hdu: LOAD_LAT must be 1..4 and CNT_W >= 1");
    end

    // Entry 0 tracks the instruction in EX; entry k is k stages further down.
    logic [LOAD_LAT-1:0] vld_q, vld_d;
    logic [REG_AW-1:0]   dst_q [LOAD_LAT];
    logic [REG_AW-1:0]   dst_d [LOAD_LAT];
    logic                hazard;

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (vld_q[k] && (dst_q[k] != '0) &&
                ((dst_q[k] == rs_i && rs_used_i) || (dst_q[k] == rt_i && rt_used_i))) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        vld_d = vld_q;
        dst_d = dst_q;
        if (!Mem_Busy_i) begin
            for (int k = LOAD_LAT - 1; k > 0; k--) begin
                vld_d[k] = vld_q[k-1];
                dst_d[k] = dst_q[k-1];
            end
            // A flushed or bubbled slot carries no load into EX.
            vld_d[0] = ID_MEMRead_i && !Flush_i && !hazard;
            dst_d[0] = ID_Rt_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // NOTE: destinations are storage gated by vld, so they are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        dst_q <= dst_d;
    end

    always_comb begin
        PCWrite_o    = 1'b1;
        IF_IDWrite_o = 1'b1;
        Stall_o      = 1'b0;
        if (rst_i) begin
            PCWrite_o    = 1'b1;
        end else if (Mem_Busy_i) begin
            PCWrite_o    = 1'b0;
            IF_IDWrite_o = 1'b0;
        end else if (!Flush_i && hazard) begin
            PCWrite_o    = 1'b0;
            IF_IDWrite_o = 1'b0;
            Stall_o      = 1'b1;
        end
    end

`ifdef HDU_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Stall_Cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_load_use_scoreboard_hdu.sv
// Self-checking bench: LOAD_LAT=1 and LOAD_LAT=2 instances share stimulus; expected
// {PCWrite, IF_IDWrite, Stall} triples are queued at drive time and compared at the falling edge.
module tb_load_use_scoreboard_hdu;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [REG_AW-1:0] rs_i, rt_i, ID_Rt_i;
    logic              rs_used_i, rt_used_i, ID_MEMRead_i, Flush_i, Mem_Busy_i;
    logic              pcw1, ifw1, st1, pcw2, ifw2, st2;
`ifdef HDU_STALL_CNT_EN
    logic [CNT_W-1:0]  cnt1, cnt2;
`endif

    typedef struct {
        string    tag;
        logic [2:0] e1;
        logic [2:0] e2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    load_use_scoreboard_hdu #(.REG_AW(REG_AW), .LOAD_LAT(1), .CNT_W(CNT_W)) u_l1 (
        .clk_i(clk_i), .rst_i(rst_i), .rs_i(rs_i), .rt_i(rt_i),
        .rs_used_i(rs_used_i), .rt_used_i(rt_used_i), .ID_MEMRead_i(ID_MEMRead_i),
        .ID_Rt_i(ID_Rt_i), .Flush_i(Flush_i), .Mem_Busy_i(Mem_Busy_i),
        .PCWrite_o(pcw1), .IF_IDWrite_o(ifw1), .Stall_o(st1)
`ifdef HDU_STALL_CNT_EN
        , .Stall_Cnt_o(cnt1)
`endif
    );

    load_use_scoreboard_hdu #(.REG_AW(REG_AW), .LOAD_LAT(2), .CNT_W(CNT_W)) u_l2 (
        .clk_i(clk_i), .rst_i(rst_i), .rs_i(rs_i), .rt_i(rt_i),
        .rs_used_i(rs_used_i), .rt_used_i(rt_used_i), .ID_MEMRead_i(ID_MEMRead_i),
        .ID_Rt_i(ID_Rt_i), .Flush_i(Flush_i), .Mem_Busy_i(Mem_Busy_i),
        .PCWrite_o(pcw2), .IF_IDWrite_o(ifw2), .Stall_o(st2)
`ifdef HDU_STALL_CNT_EN
        , .Stall_Cnt_o(cnt2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] e1, input logic [2:0] e2);
        exp_t e;
        e.tag = tag;
        e.e1  = e1;
        e.e2  = e2;
        exp_q.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "/L1"}, {29'd0, pcw1, ifw1, st1}, {29'd0, e.e1});
            check({e.tag, "/L2"}, {29'd0, pcw2, ifw2, st2}, {29'd0, e.e2});
        end
    endtask

    task automatic step(input string tag,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu,
                        input logic ld, input logic [4:0] ldrt,
                        input logic fl, input logic bz,
                        input logic [2:0] e1, input logic [2:0] e2);
        @(posedge clk_i);
        #1;
        rs_i = rs; rt_i = rt; rs_used_i = rsu; rt_used_i = rtu;
        ID_MEMRead_i = ld; ID_Rt_i = ldrt; Flush_i = fl; Mem_Busy_i = bz;
        push_exp(tag, e1, e2);
        @(negedge clk_i);
        compare_front();
    endtask

    // lw $d, 0($29)
    task automatic lw(input string tag, input logic [4:0] d, input logic [2:0] e1, input logic [2:0] e2);
        step(tag, 5'd29, d, 1'b1, 1'b0, 1'b1, d, 1'b0, 1'b0, e1, e2);
    endtask

    // R-type reading rs and rt
    task automatic alu(input string tag, input logic [4:0] s, input logic [4:0] t,
                       input logic bz, input logic [2:0] e1, input logic [2:0] e2);
        step(tag, s, t, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, bz, e1, e2);
    endtask

    task automatic nop(input string tag);
        step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'b110, 3'b110);
    endtask

    initial begin
        rst_i = 1'b1;
        rs_i = '0; rt_i = '0; rs_used_i = 1'b0; rt_used_i = 1'b0;
        ID_MEMRead_i = 1'b0; ID_Rt_i = '0; Flush_i = 1'b0; Mem_Busy_i = 1'b0;

        // Reset state
        #2;
        push_exp("reset", 3'b110, 3'b110);
        compare_front();
`ifdef HDU_STALL_CNT_EN
        check("reset_cnt/L1", {16'd0, cnt1}, 32'd0);
        check("reset_cnt/L2", {16'd0, cnt2}, 32'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b0;

        // Back-to-back dependent instruction
        lw ("a_lw2",     5'd2,              3'b110, 3'b110);
        alu("a_add1",    5'd2, 5'd4, 1'b0,  3'b001, 3'b001);
        alu("a_add2",    5'd2, 5'd4, 1'b0,  3'b110, 3'b001);
        alu("a_add3",    5'd2, 5'd4, 1'b0,  3'b110, 3'b110);
        nop("a_nop");

        // One independent filler instruction
        lw ("b_lw2",     5'd2,              3'b110, 3'b110);
        alu("b_or",      5'd6, 5'd7, 1'b0,  3'b110, 3'b110);
        alu("b_add1",    5'd2, 5'd4, 1'b0,  3'b110, 3'b001);
        alu("b_add2",    5'd2, 5'd4, 1'b0,  3'b110, 3'b110);
        nop("b_nop");

        // Loads to $0 never match; unused rt never matches
        lw ("c_lw0",     5'd0,              3'b110, 3'b110);
        alu("c_rd0a",    5'd0, 5'd0, 1'b0,  3'b110, 3'b110);
        alu("c_rd0b",    5'd0, 5'd0, 1'b0,  3'b110, 3'b110);
        lw ("c_lw2",     5'd2,              3'b110, 3'b110);
        step("c_rt2u_a", 5'd3, 5'd2, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 3'b110, 3'b110);
        step("c_rt2u_b", 5'd3, 5'd2, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 3'b110, 3'b110);
        nop("c_nop");

        // Memory busy freezes a pending hazard
        lw ("d_lw2",     5'd2,              3'b110, 3'b110);
        alu("d_busy1",   5'd2, 5'd4, 1'b1,  3'b000, 3'b000);
        alu("d_busy2",   5'd2, 5'd4, 1'b1,  3'b000, 3'b000);
        alu("d_busy3",   5'd2, 5'd4, 1'b1,  3'b000, 3'b000);
        alu("d_add1",    5'd2, 5'd4, 1'b0,  3'b001, 3'b001);
        alu("d_add2",    5'd2, 5'd4, 1'b0,  3'b110, 3'b001);
        alu("d_add3",    5'd2, 5'd4, 1'b0,  3'b110, 3'b110);
        nop("d_nop");

        // Flush wins over a hazard on a load in ID; that load is not recorded
        lw ("e_lw2",     5'd2,              3'b110, 3'b110);
        step("e_flush",  5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 3'b110, 3'b110);
        alu("e_rd5a",    5'd5, 5'd5, 1'b0,  3'b110, 3'b110);
        alu("e_rd5b",    5'd5, 5'd5, 1'b0,  3'b110, 3'b110);
        nop("e_nop");

        // Asynchronous reset in the middle of a stall
        lw ("f_lw2",     5'd2,              3'b110, 3'b110);
        alu("f_add1",    5'd2, 5'd4, 1'b0,  3'b001, 3'b001);
        alu("f_add2",    5'd2, 5'd4, 1'b0,  3'b110, 3'b001);
        #2;
        rst_i = 1'b1;
        #1;
        push_exp("f_rst", 3'b110, 3'b110);
        compare_front();
`ifdef HDU_STALL_CNT_EN
        check("f_rst_cnt/L1", {16'd0, cnt1}, 32'd0);
        check("f_rst_cnt/L2", {16'd0, cnt2}, 32'd0);
`endif
        #1;
        rst_i = 1'b0;
        alu("f_post",    5'd2, 5'd4, 1'b0,  3'b110, 3'b110);
        lw ("g_lw2",     5'd2,              3'b110, 3'b110);
        alu("g_add1",    5'd2, 5'd4, 1'b0,  3'b001, 3'b001);
        alu("g_add2",    5'd2, 5'd4, 1'b0,  3'b110, 3'b001);
        alu("g_add3",    5'd2, 5'd4, 1'b0,  3'b110, 3'b110);
`ifdef HDU_STALL_CNT_EN
        check("g_cnt/L1", {16'd0, cnt1}, 32'd1);
        check("g_cnt/L2", {16'd0, cnt2}, 32'd2);
`endif
        nop("g_nop");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
